thirty_two_bit_divider: RTL

- Sequential restoring divider. It is the inverse datapath to the 32-bit multiplier and serves the M-extension DIV/DIVU/REM/REMU instructions in the execute stage.
- Produces quotient and remainder together, one quotient bit per cycle, with the RISC-V-mandated results for divide-by-zero and signed overflow.
- Uses a start/busy/complete_signal handshake toward the execute-stage controller.

---
 rtl/thirty_two_bit_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/thirty_two_bit_divider.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with the RISC-V results for divide-by-zero and signed overflow produced in one cycle.
module thirty_two_bit_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] operator_1,
  input  logic [XLEN-1:0] operator_2,
  output logic            busy,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            complete_signal
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [XLEN-1:0] prem_reg, prem_next;
  logic [XLEN-1:0] dvd_reg, dvd_next;
  logic [XLEN-1:0] dvs_reg, dvs_next;
  logic [XLEN-1:0] quotient_reg, quotient_next;
  logic [XLEN-1:0] remainder_reg, remainder_next;
  logic            q_neg_reg, q_neg_next;
  logic            r_neg_reg, r_neg_next;
  logic            complete_reg, complete_next;

  logic            sign1, sign2, div_zero, overflow;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   shifted, trial;

  assign sign1    = is_signed & operator_1[XLEN-1];
  assign sign2    = is_signed & operator_2[XLEN-1];
  assign abs1     = sign1 ? -operator_1 : operator_1;
  assign abs2     = sign2 ? -operator_2 : operator_2;
  assign div_zero = (operator_2 == '0);
  assign overflow = is_signed && (operator_1 == {1'b1, {(XLEN-1){1'b0}}}) && (operator_2 == '1);

  // The partial remainder is always below the divisor, so only the shifted
  // trial value needs the extra 33rd bit; trial[XLEN] is the borrow.
  assign shifted = {prem_reg, dvd_reg[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    prem_next      = prem_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    q_neg_next     = q_neg_reg;
    r_neg_next     = r_neg_reg;
    complete_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            quotient_next  = '1;
            remainder_next = operator_1;
            complete_next  = 1'b1;
            state_next     = DONE;
          end else if (overflow) begin
            quotient_next  = operator_1;
            remainder_next = '0;
            complete_next  = 1'b1;
            state_next     = DONE;
          end else begin
            dvd_next   = abs1;
            dvs_next   = abs2;
            q_neg_next = sign1 ^ sign2;
            r_neg_next = sign1;
            prem_next  = '0;
            count_next = '0;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (trial[XLEN]) begin
          prem_next = shifted[XLEN-1:0];
          dvd_next  = {dvd_reg[XLEN-2:0], 1'b0};
        end else begin
          prem_next = trial[XLEN-1:0];
          dvd_next  = {dvd_reg[XLEN-2:0], 1'b1};
        end
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(XLEN - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        quotient_next  = q_neg_reg ? -dvd_reg : dvd_reg;
        remainder_next = r_neg_reg ? -prem_reg : prem_reg;
        complete_next  = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      prem_reg      <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      complete_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      prem_reg      <= prem_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      complete_reg  <= complete_next;
    end
  end

  assign busy            = (state_reg != IDLE);
  assign quotient        = quotient_reg;
  assign remainder       = remainder_reg;
  assign complete_signal = complete_reg;

endmodule
